// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, byte width and
// a small round-robin pointer helper.
package uart_tx_sched_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr, wrapping,
// is returned as both a one-hot grant and an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotating by ptr puts the highest-priority request at bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    valid = |rot;
    sum   = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
    gnt = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler sharing one uart_tx between NUM_REQ byte sources.
// A grant is held from the first byte of a packet until its last byte's frame completes.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BUSY_TMO = 16,
  parameter int HOLD_TMO = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           pkt_abort,
  output logic                           uart_tx_en,
  output logic [UART_DATA_W-1:0]         uart_tx_data,
  input  logic                           uart_tx_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(HOLD_TMO + 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   last_q, last_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   en_q, en_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   abort_q, abort_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic [NUM_REQ-1:0]     win_onehot;
  logic [IW-1:0]          win_idx;
  logic                   win_valid;

  logic [IW-1:0]          sel_idx;
  logic                   sel_req;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_data;
  logic [NUM_REQ-1:0]     sel_onehot;
  logic                   accept;
  logic                   drop_grant;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (win_onehot),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // In IDLE the arbiter picks the source; afterwards only the owner is looked at.
  assign sel_idx    = (state_q == ST_IDLE) ? win_idx : gidx_q;
  assign sel_req    = req[sel_idx];
  assign sel_last   = req_last[sel_idx];
  assign sel_data   = req_data[{sel_idx, 3'b000} +: UART_DATA_W];
  assign sel_onehot = NUM_REQ'(1) << sel_idx;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    last_d     = last_q;
    ack_d      = '0;
    en_d       = 1'b0;
    data_d     = data_q;
    abort_d    = 1'b0;
    timer_d    = timer_q;
    accept     = 1'b0;
    drop_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_valid && !uart_tx_busy) begin
          accept  = 1'b1;
          gidx_d  = win_idx;
          grant_d = win_onehot;
        end
      end
      ST_WAIT_HI: begin
        if (uart_tx_busy || timer_q >= TW'(BUSY_TMO - 1)) begin
          state_d = ST_WAIT_LO;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            drop_grant = 1'b1;
          end else if (sel_req) begin
            accept = 1'b1;
          end else begin
            state_d = ST_HOLD;
            timer_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (sel_req) begin
          accept = 1'b1;
        end else if (timer_q >= TW'(HOLD_TMO - 1)) begin
          abort_d    = 1'b1;
          drop_grant = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      en_d    = 1'b1;
      ack_d   = sel_onehot;
      data_d  = sel_data;
      last_d  = sel_last;
      state_d = ST_WAIT_HI;
      timer_d = '0;
    end

    if (drop_grant) begin
      grant_d  = '0;
      rr_ptr_d = IW'(wrap_inc(int'(gidx_q), NUM_REQ));
      state_d  = ST_IDLE;
      timer_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      last_q   <= 1'b0;
      ack_q    <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      abort_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      en_q     <= en_d;
      data_q   <= data_d;
      abort_q  <= abort_d;
      timer_q  <= timer_d;
    end
  end

  assign req_ack      = ack_q;
  assign grant        = grant_q;
  assign pkt_abort    = abort_q;
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;

endmodule
